// File: rtl/fir_dec_pkg.sv
// Shared definitions for the FIR decimating output stage.
//   dec_state_t : sample-selection FSM states (idle, warm-up discard, run).
//   DEF_*       : default sample width, decimation factor, warm-up length and
//                 FIFO depth, kept in one place so the FIR top level and this
//                 stage agree.
package fir_dec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } dec_state_t;

  localparam int DEF_DATA_W = 16;  // signed 1.1.14 FIR output
  localparam int DEF_DECIM  = 4;
  localparam int DEF_WARMUP = 11;  // FIR register latency (5) + tap-line fill (6)
  localparam int DEF_DEPTH  = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset (flushes pointers)
//   push_i       : write wdata_i (accepted when not full, or full with pop_i)
//   wdata_i      : write data
//   pop_i        : consume the head entry (ignored when empty)
//   rdata_o      : head entry, zero while empty
//   full_o       : DEPTH entries held
//   empty_o      : no entries held
//   level_o      : occupancy, 0..DEPTH
module sync_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push_i,
  input  logic [DATA_W-1:0]         wdata_i,
  input  logic                      pop_i,
  output logic [DATA_W-1:0]         rdata_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [$clog2(DEPTH):0]    level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              wr_en, rd_en;

  // Extra MSB on each pointer distinguishes full from empty when the
  // address bits match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;

  // A full FIFO still takes a write when the head leaves on the same edge:
  // the slot being written is the one being read out this cycle.
  assign rd_en = pop_i && !empty_o;
  assign wr_en = push_i && (!full_o || rd_en);

  // Gate the head with empty so stale storage never shows on the output.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage has no reset; resetting the pointers empties the FIFO and
  // the output gating hides old contents, so the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/fir_decim_fifo.sv
// Output stage of the 7-tap FIR: drops pipeline warm-up samples, keeps one
// sample in DECIM, and buffers kept samples for a valid/ready consumer.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   en               : upstream running, one filtered_signal sample per cycle
//   filtered_signal  : signed FIR sample
//   m_data, m_valid  : FWFT head of the buffer
//   m_ready          : consumer takes m_data this cycle
//   overflow         : sticky, a kept sample was lost to a full buffer
//   clr_ovf          : synchronous clear of overflow (a new drop wins)
//   fill_level       : buffer occupancy, 0..DEPTH
module fir_decim_fifo
  import fir_dec_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DECIM  = DEF_DECIM,
  parameter int WARMUP = DEF_WARMUP,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [DATA_W-1:0]      filtered_signal,
  output logic [DATA_W-1:0]      m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   overflow,
  input  logic                   clr_ovf,
  output logic [$clog2(DEPTH):0] fill_level
);

  localparam int CW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

  dec_state_t    state_q, state_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          ovf_q, ovf_d;
  logic          keep, pop, drop, push;
  logic          full, empty;

  // Sample selection. The warm-up counter holds the index of the current
  // sample since en rose; the IDLE cycle that first sees en is index 0, so
  // the first kept sample is index WARMUP.
  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    phase_d = phase_q;
    keep    = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
      wcnt_d  = '0;
      phase_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (WARMUP == 0) begin
            keep    = 1'b1;
            state_d = ST_RUN;
            phase_d = (DECIM > 1) ? PW'(1) : '0;
          end else if (WARMUP == 1) begin
            state_d = ST_RUN;
            phase_d = '0;
          end else begin
            state_d = ST_WARMUP;
            wcnt_d  = CW'(1);
          end
        end
        ST_WARMUP: begin
          if (wcnt_q == CW'(WARMUP - 1)) begin
            state_d = ST_RUN;
            wcnt_d  = '0;
            phase_d = '0;
          end else begin
            wcnt_d = wcnt_q + CW'(1);
          end
        end
        ST_RUN: begin
          keep    = (phase_q == '0);
          phase_d = (phase_q == PW'(DECIM - 1)) ? '0 : phase_q + PW'(1);
        end
        default: begin
          state_d = ST_IDLE;
          wcnt_d  = '0;
          phase_d = '0;
        end
      endcase
    end
  end

  assign m_valid = !empty;
  assign pop     = m_valid && m_ready;
  // A kept sample is lost only when the buffer is full and nothing leaves.
  assign drop    = keep && full && !pop;
  assign push    = keep && !drop;

  always_comb begin
    ovf_d = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      phase_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      phase_q <= phase_d;
      ovf_q   <= ovf_d;
    end
  end

  assign overflow = ovf_q;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (filtered_signal),
    .pop_i   (pop),
    .rdata_o (m_data),
    .full_o  (full),
    .empty_o (empty),
    .level_o (fill_level)
  );

endmodule

// File: tb/tb_fir_decim_fifo.sv
// Directed bench for fir_decim_fifo with default parameters
// (DECIM=4, WARMUP=11, DEPTH=8). Inputs change 1 time unit after each rising
// edge; outputs are sampled at the same point.
module tb_fir_decim_fifo;
  import fir_dec_pkg::*;

  localparam int LW = $clog2(DEF_DEPTH) + 1;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  en;
  logic [DEF_DATA_W-1:0] filtered_signal;
  logic [DEF_DATA_W-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  overflow;
  logic                  clr_ovf;
  logic [LW-1:0]         fill_level;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fir_decim_fifo dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en              (en),
    .filtered_signal (filtered_signal),
    .m_data          (m_data),
    .m_valid         (m_valid),
    .m_ready         (m_ready),
    .overflow        (overflow),
    .clr_ovf         (clr_ovf),
    .fill_level      (fill_level)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en              = 1'b0;
    m_ready         = 1'b0;
    clr_ovf         = 1'b0;
    filtered_signal = '0;
    rst_n           = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Backpressured run: kept samples 11,15,..,39 fill the buffer, 43 is lost.
  task automatic fill_to_overflow();
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 43; i++) begin
      filtered_signal = DEF_DATA_W'(i);
      step();
    end
    check("bp_fill8", fill_level, 8);
    check("bp_no_ovf_yet", overflow, 0);
    filtered_signal = DEF_DATA_W'(43);
    step();
    check("bp_ovf_set", overflow, 1);
    check("bp_fill_still8", fill_level, 8);
    check("bp_head11", m_data, 11);
  endtask

  initial begin
    logic exp_v;

    // Reset state and basic decimation
    do_reset();
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_fill", fill_level, 0);
    check("rst_ovf", overflow, 0);
    m_ready = 1'b1;
    en      = 1'b1;
    for (int i = 0; i < 24; i++) begin
      filtered_signal = DEF_DATA_W'(i);
      step();
      exp_v = (i >= 11) && (((i - 11) % 4) == 0);
      check($sformatf("dec_valid_%0d", i), m_valid, exp_v);
      if (exp_v) check($sformatf("dec_data_%0d", i), m_data, i);
    end

    // Backpressure, overflow, ordered drain, then clean clear
    fill_to_overflow();
    en      = 1'b0;
    m_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("drain_valid_%0d", k), m_valid, 1);
      check($sformatf("drain_data_%0d", k), m_data, 11 + 4 * k);
      step();
    end
    check("drain_empty", m_valid, 0);
    check("drain_fill0", fill_level, 0);
    check("drain_ovf_sticky", overflow, 1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("clr_ovf", overflow, 0);

    // Full with a pop on the phase-0 cycle, then clear/drop race
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 44; i++) begin
      filtered_signal = DEF_DATA_W'(i);
      m_ready         = (i == 43);
      step();
    end
    m_ready = 1'b0;
    check("fullpop_fill8", fill_level, 8);
    check("fullpop_no_ovf", overflow, 0);
    check("fullpop_head15", m_data, 15);
    for (int i = 44; i < 48; i++) begin
      filtered_signal = DEF_DATA_W'(i);
      step();
    end
    check("race_drop_ovf", overflow, 1);
    for (int i = 48; i < 52; i++) begin
      filtered_signal = DEF_DATA_W'(i);
      clr_ovf         = (i == 51);
      step();
    end
    check("race_set_wins", overflow, 1);
    filtered_signal = DEF_DATA_W'(52);
    clr_ovf         = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("race_later_clr", overflow, 0);
    check("race_fill8", fill_level, 8);

    // en toggle: buffer keeps draining, warm-up restarts
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      filtered_signal = DEF_DATA_W'(i);
      step();
    end
    check("tog_fill3", fill_level, 3);
    en      = 1'b0;
    m_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("tog_drain_data_%0d", k), m_data, 11 + 4 * k);
      step();
      check($sformatf("tog_drain_fill_%0d", k), fill_level, 2 - k);
    end
    check("tog_empty", m_valid, 0);
    en = 1'b1;
    for (int j = 0; j < 13; j++) begin
      filtered_signal = DEF_DATA_W'(100 + j);
      step();
      exp_v = (j == 11);
      check($sformatf("tog_valid_%0d", j), m_valid, exp_v);
      if (exp_v) check("tog_first_kept", m_data, 111);
    end

    // Asynchronous reset mid-operation
    fill_to_overflow();
    en      = 1'b0;
    m_ready = 1'b1;
    repeat (3) step();
    m_ready = 1'b0;
    check("mid_fill5", fill_level, 5);
    check("mid_ovf1", overflow, 1);
    check("mid_head23", m_data, 23);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid0", m_valid, 0);
    check("async_data0", m_data, 0);
    check("async_fill0", fill_level, 0);
    check("async_ovf0", overflow, 0);
    step();
    rst_n   = 1'b1;
    m_ready = 1'b1;
    en      = 1'b1;
    for (int i = 0; i < 12; i++) begin
      filtered_signal = DEF_DATA_W'(i);
      step();
      if (i == 10) check("post_rst_valid10", m_valid, 0);
    end
    check("post_rst_valid11", m_valid, 1);
    check("post_rst_data11", m_data, 11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
